// File: rtl/nbit_updown_counter_with_synch_load_enable_clear.sv
// nbit_updown_counter_with_synch_load_enable_clear: WIDTH-bit modulo-(MAX_COUNT+1) up/down counter with sync clear, clamped load, enable, one-shot halt; ports Clock, Clear, Enable, Load, Up, OneShot, D -> Q, TC (comb), Done; define COUNTER_SATURATE_EN to saturate instead of wrap in free-run
module nbit_updown_counter_with_synch_load_enable_clear #(
  parameter int WIDTH = 4,
  parameter int MAX_COUNT = 9
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Enable,
  input  logic             Load,
  input  logic             Up,
  input  logic             OneShot,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Done
);
  if (WIDTH < 1 || MAX_COUNT < 0 || (WIDTH < 32 && (MAX_COUNT >> WIDTH) != 0)) begin : g_bad_param
    $error("MAX_COUNT must fit in WIDTH bits");
  end
`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] q_nx, q_step;
  logic t, done_nx;
  assign t = Up ? (Q == MAXV) : (Q == '0);
  assign TC = Enable & t & (state == RUN);
  assign q_step = t ? ((OneShot | SAT) ? Q : (Up ? '0 : MAXV)) : (Up ? Q + WIDTH'(1) : Q - WIDTH'(1));
  always_comb begin
    q_nx = Q;
    state_nx = state;
    done_nx = Done;
    if (Load) begin
      q_nx = (D > MAXV) ? MAXV : D;
      state_nx = RUN;
      done_nx = 1'b0;
    end else if (Enable && state == RUN) begin
      q_nx = q_step;
      state_nx = (t && OneShot) ? HALT : RUN;
      done_nx = t & OneShot;
    end
  end
  always_ff @(posedge Clock) begin
    if (Clear) begin
      Q <= '0;
      state <= RUN;
      Done <= 1'b0;
    end else begin
      Q <= q_nx;
      state <= state_nx;
      Done <= done_nx;
    end
  end
endmodule

// File: tb/tb_nbit_updown_counter_with_synch_load_enable_clear.sv
// tb_nbit_updown_counter_with_synch_load_enable_clear: table-driven directed check of the modulo-10 counter
module tb_nbit_updown_counter_with_synch_load_enable_clear;
  logic clk = 1'b0;
  logic clear = 1'b0, enable = 1'b0, load = 1'b0, up = 1'b0, oneshot = 1'b0;
  logic [3:0] d = '0, q;
  logic tc, done;
  int tests = 0, failed = 0;
  typedef struct {
    logic clr, ld, en, up, os;
    logic [3:0] d, q;
    logic tc, done;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  nbit_updown_counter_with_synch_load_enable_clear #(.WIDTH(4), .MAX_COUNT(9)) dut (
    .Clock(clk), .Clear(clear), .Enable(enable), .Load(load), .Up(up),
    .OneShot(oneshot), .D(d), .Q(q), .TC(tc), .Done(done)
  );
  task automatic add(input logic c, l, e, u, o, input logic [3:0] dv, qv, input logic tv, dn);
    vecs.push_back('{c, l, e, u, o, dv, qv, tv, dn});
  endtask
  task automatic chk(input string nm, input int i, input logic [3:0] act, exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %0d want %0d", nm, i, act, exp);
    end
  endtask
  initial begin
    // clr ld en up os d  q  tc done
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) add(0, 0, 1, 1, 0, 0, 4'(k % 10), k == 9, 0);
    add(0, 1, 0, 0, 0, 4, 4, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 9, 0, 0);
    add(0, 0, 1, 0, 0, 0, 8, 0, 0);
    add(0, 1, 0, 0, 0, 15, 9, 0, 0);
    add(1, 1, 0, 0, 0, 5, 0, 0, 0);
    add(0, 1, 0, 1, 1, 7, 7, 0, 0);
    add(0, 0, 1, 1, 1, 0, 8, 0, 0);
    add(0, 0, 1, 1, 1, 0, 9, 1, 0);
    add(0, 0, 1, 1, 1, 0, 9, 0, 1);
    add(0, 0, 1, 1, 1, 0, 9, 0, 1);
    add(0, 0, 1, 0, 0, 0, 9, 0, 1);
    add(0, 1, 0, 1, 1, 2, 2, 0, 0);
    add(0, 0, 1, 1, 1, 0, 3, 0, 0);
    add(0, 0, 1, 1, 1, 0, 4, 0, 0);
    add(0, 0, 1, 1, 0, 0, 5, 0, 0);
    add(0, 0, 0, 1, 0, 0, 5, 0, 0);
    add(0, 0, 0, 1, 0, 0, 5, 0, 0);
    add(0, 0, 0, 1, 0, 0, 5, 0, 0);
    add(0, 0, 1, 1, 0, 0, 6, 0, 0);
    add(0, 0, 1, 0, 0, 0, 5, 0, 0);
    add(0, 0, 1, 0, 0, 0, 4, 0, 0);
    add(0, 1, 0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 1, 0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 8, 8, 0, 0);
    add(0, 0, 1, 1, 0, 0, 9, 1, 0);
`ifdef COUNTER_SATURATE_EN
    add(0, 0, 1, 1, 0, 0, 9, 1, 0);
    add(0, 0, 1, 1, 0, 0, 9, 1, 0);
    add(0, 1, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 0);
`else
    add(0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 9, 0, 0);
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clear = vecs[i].clr;
      load = vecs[i].ld;
      enable = vecs[i].en;
      up = vecs[i].up;
      oneshot = vecs[i].os;
      d = vecs[i].d;
      @(posedge clk);
      #1;
      chk("q", i, q, vecs[i].q);
      chk("tc", i, {3'b0, tc}, {3'b0, vecs[i].tc});
      chk("done", i, {3'b0, done}, {3'b0, vecs[i].done});
    end
    @(negedge clk);
    clear = 1'b1; load = 1'b0; enable = 1'b0; up = 1'b0; oneshot = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_q", 0, q, 4'd0);
    chk("rst_tc_idle", 0, {3'b0, tc}, 4'd0);
    enable = 1'b1;
    #1;
    chk("tc_down_at_zero", 0, {3'b0, tc}, 4'd1);
    up = 1'b1;
    #1;
    chk("tc_up_at_zero", 0, {3'b0, tc}, 4'd0);
    up = 1'b0;
    #1;
    chk("q_no_edge", 0, q, 4'd0);
    @(negedge clk);
    clear = 1'b0; enable = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
